// File: rtl/cmsdk_sram_init_ctrl.sv
// Single-port SRAM with byte-lane writes, optional output register and a zero-fill init engine.
// Define SRAM_PARITY_EN to store and check one even-parity bit per byte lane.
module cmsdk_sram_init_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [AW-1:0]     ADDR,
    input  logic [DW-1:0]     WDATA,
    input  logic [DW/8-1:0]   WREN,
    input  logic              CS,
    input  logic              INIT_REQ,
    output logic [DW-1:0]     RDATA,
    output logic              RVALID,
    output logic              INIT_DONE,
    output logic [DW/8-1:0]   PERR
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          cnt_last;
    logic          run;
    logic          acc_ok;
    logic          wr_en;
    logic          rd_en;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_word;

    logic          out_en;
    logic [DW-1:0] out_data;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    assign cnt_last = (cnt == {AW{1'b1}});
    assign run      = (state == ST_RUN);
    // INIT_REQ outranks any access presented in the same cycle.
    assign acc_ok   = run && CS && !INIT_REQ;
    assign wr_en    = acc_ok && (|WREN);
    assign rd_en    = acc_ok && !(|WREN);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (INIT_REQ) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign INIT_DONE = run;

    // Array contents are deliberately not reset; only the init walk clears them.
    always_ff @(posedge CLK) begin
        if (!run) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (WREN[i]) begin
                    mem[ADDR][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[ADDR];

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          pipe_valid;
            logic [DW-1:0] pipe_data;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                end else begin
                    pipe_valid <= rd_en;
                    if (rd_en) begin
                        pipe_data <= rd_word;
                    end
                end
            end

            assign out_en   = pipe_valid;
            assign out_data = pipe_data;
        end else begin : g_out_direct
            assign out_en   = rd_en;
            assign out_data = rd_word;
        end
    endgenerate

    // The output stage is never flushed, so a read in flight still completes during INIT.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= out_en;
            if (out_en) begin
                rdata_q <= out_data;
            end
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] rd_par;
    logic [NB-1:0] out_par;
    logic [NB-1:0] perr_calc;
    logic [NB-1:0] perr_q;

    always_ff @(posedge CLK) begin
        if (!run) begin
            mem_par[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (WREN[i]) begin
                    mem_par[ADDR][i] <= ^WDATA[8*i +: 8];
                end
            end
        end
    end

    assign rd_par = mem_par[ADDR];

    generate
        if (OUT_REG != 0) begin : g_par_reg
            logic [NB-1:0] par_q;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    par_q <= '0;
                end else if (rd_en) begin
                    par_q <= rd_par;
                end
            end

            assign out_par = par_q;
        end else begin : g_par_direct
            assign out_par = rd_par;
        end
    endgenerate

    always_comb begin
        perr_calc = '0;
        for (int i = 0; i < NB; i++) begin
            perr_calc[i] = out_par[i] ^ (^out_data[8*i +: 8]);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            perr_q <= '0;
        end else if (out_en) begin
            perr_q <= perr_calc;
        end else begin
            perr_q <= '0;
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = '0;
`endif

endmodule

// File: tb/tb_cmsdk_sram_init_ctrl.sv
// Directed self-checking bench for cmsdk_sram_init_ctrl (AW=4, DW=32).
module tb_cmsdk_sram_init_ctrl;

    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int NB      = DW / 8;
    localparam int OUT_REG = 0;
    localparam int LAT     = 1 + OUT_REG;

    logic            CLK;
    logic            RESETn;
    logic [AW-1:0]   ADDR;
    logic [DW-1:0]   WDATA;
    logic [NB-1:0]   WREN;
    logic            CS;
    logic            INIT_REQ;
    logic [DW-1:0]   RDATA;
    logic            RVALID;
    logic            INIT_DONE;
    logic [NB-1:0]   PERR;

    int total;
    int bad;

    logic [DW-1:0] bb_exp [3];

    cmsdk_sram_init_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .OUT_REG (OUT_REG)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .WREN      (WREN),
        .CS        (CS),
        .INIT_REQ  (INIT_REQ),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .INIT_DONE (INIT_DONE),
        .PERR      (PERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [NB-1:0] wren, input logic initReq);
        CS       = cs;
        ADDR     = addr;
        WDATA    = wdata;
        WREN     = wren;
        INIT_REQ = initReq;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Expects the 16 init edges to start at the next rising edge.
    task automatic checkInitWindow(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
            checkOutput({tag, "_done"}, INIT_DONE, (i == 16));
            checkOutput({tag, "_rvalid"}, RVALID, 1'b0);
        end
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [NB-1:0] wren);
        applyStimulus(1'b1, addr, data, wren, 1'b0);
        @(negedge CLK);
        idle();
        checkOutput("wr_rvalid", RVALID, 1'b0);
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] expData, input logic [NB-1:0] expPerr);
        applyStimulus(1'b1, addr, '0, '0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge CLK);
            if (k == 1) idle();
            checkOutput("rd_rvalid", RVALID, (k == LAT));
        end
        checkOutput("rd_data", RDATA, expData);
        checkOutput("rd_perr", PERR, expPerr);
        @(negedge CLK);
        checkOutput("rd_pulse_end", RVALID, 1'b0);
        checkOutput("rd_perr_idle", PERR, '0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        bb_exp = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        RESETn = 1'b0;
        idle();
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rst_rdata", RDATA, '0);
        checkOutput("rst_rvalid", RVALID, 1'b0);
        checkOutput("rst_done", INIT_DONE, 1'b0);
        checkOutput("rst_perr", PERR, '0);

        // Reads held on CS throughout init must be ignored.
        applyStimulus(1'b1, 4'd7, '0, '0, 1'b0);
        RESETn = 1'b1;
        checkInitWindow("init1");
        idle();
        doRead(4'd7, 32'h0, 4'h0);

        doWrite(4'd3, 32'hDEAD_BEEF, 4'hF);
        doWrite(4'd3, 32'h0000_00AA, 4'b0001);
        doRead(4'd3, 32'hDEAD_BEAA, 4'h0);

        doWrite(4'd0, 32'h11, 4'hF);
        doWrite(4'd1, 32'h22, 4'hF);
        doWrite(4'd2, 32'h33, 4'hF);
        for (int k = 0; k < 3 + LAT; k++) begin
            if (k < 3) applyStimulus(1'b1, k[AW-1:0], '0, '0, 1'b0);
            else       idle();
            @(negedge CLK);
            if ((k + 1 >= LAT) && (k + 1 - LAT < 3)) begin
                checkOutput("b2b_rvalid", RVALID, 1'b1);
                checkOutput("b2b_rdata", RDATA, bb_exp[k + 1 - LAT]);
            end else begin
                checkOutput("b2b_gap", RVALID, 1'b0);
            end
        end
        idle();
        @(negedge CLK);
        checkOutput("b2b_hold", RDATA, 32'h33);

        // Read collides with INIT_REQ: dropped, array re-zeroed.
        applyStimulus(1'b1, 4'd1, '0, '0, 1'b1);
        @(negedge CLK);
        idle();
        checkOutput("req_done_drop", INIT_DONE, 1'b0);
        checkOutput("req_rvalid", RVALID, 1'b0);
        checkInitWindow("init2");
        checkOutput("req_hold", RDATA, 32'h33);
        doRead(4'd0, 32'h0, 4'h0);
        doRead(4'd1, 32'h0, 4'h0);
        doRead(4'd2, 32'h0, 4'h0);
        doRead(4'd3, 32'h0, 4'h0);

        // Asynchronous reset in the middle of a read.
        doWrite(4'd9, 32'h0000_0055, 4'hF);
        doRead(4'd9, 32'h0000_0055, 4'h0);
        applyStimulus(1'b1, 4'd9, '0, '0, 1'b0);
        @(posedge CLK);
        #1;
        RESETn = 1'b0;
        #1;
        checkOutput("arst_rdata", RDATA, '0);
        checkOutput("arst_rvalid", RVALID, 1'b0);
        checkOutput("arst_done", INIT_DONE, 1'b0);
        checkOutput("arst_perr", PERR, '0);
        idle();
        @(negedge CLK);
        RESETn = 1'b1;

        // Reset again at init cycle 8, then a full init must follow.
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            checkOutput("mid_done", INIT_DONE, 1'b0);
        end
        RESETn = 1'b0;
        #1;
        checkOutput("mid_rst_done", INIT_DONE, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        checkInitWindow("init3");
        doRead(4'd9, 32'h0, 4'h0);

`ifdef SRAM_PARITY_EN
        doWrite(4'd5, 32'h1234_5678, 4'hF);
        dut.mem_par[5][2] = ~dut.mem_par[5][2];
        doRead(4'd5, 32'h1234_5678, 4'b0100);
        doWrite(4'd6, 32'hA5A5_0001, 4'hF);
        doWrite(4'd6, 32'h0000_00FF, 4'b0001);
        doRead(4'd6, 32'hA5A5_00FF, 4'h0);
        doRead(4'd4, 32'h0, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
